// File: rtl/glitch_sweep_ctrl.sv
// Fault-injection sweep sequencer: reset pulse, programmable delay, glitch pulse, observe, report.
// Optional build macro GLITCH_RETRY_EN repeats each grid point RETRIES times.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start
// S_RESET   | target held in reset for RESET_CYCLES
// S_DELAY   | reset released, counting cur_delay before the glitch
// S_GLITCH  | glitch MOSFET driven for cur_len cycles
// S_OBSERVE | waiting for success/fail or timeout
// S_REPORT  | record offered to UART queue until accepted
// S_ADVANCE | step retry count or delay/length grid
// S_HIT     | success seen, target left running
// S_DONE    | grid exhausted
module glitch_sweep_ctrl #(
  parameter int             W              = 16,
  parameter int             RESET_CYCLES   = 16,
  parameter logic [W-1:0]   DELAY_MIN      = 16'h0700,
  parameter logic [W-1:0]   DELAY_MAX      = 16'h0730,
  parameter logic [W-1:0]   LEN_MIN        = 16'h0180,
  parameter logic [W-1:0]   LEN_MAX        = 16'h0190,
  parameter logic [23:0]    OBSERVE_CYCLES = 24'h100000,
  parameter int             RETRIES        = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         start,
  input  logic         abort,
  input  logic         success,
  input  logic         fail,
  output logic         reset_out,
  output logic         glitch_out,
  output logic         rec_valid,
  input  logic         rec_ready,
  output logic [W-1:0] rec_delay,
  output logic [W-1:0] rec_len,
  output logic [1:0]   rec_result,
  output logic         busy,
  output logic         hit,
  output logic         done
);

  localparam int CW    = (W > 24) ? W : 24;
  localparam int TRY_W = $clog2(RETRIES + 1);
`ifdef GLITCH_RETRY_EN
  localparam int ATTEMPTS = (RETRIES < 1) ? 1 : RETRIES;
`else
  localparam int ATTEMPTS = 1;
`endif

  localparam logic [CW-1:0]    RST_LOAD = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0]    OBS_LOAD = CW'(OBSERVE_CYCLES - 24'd1);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(ATTEMPTS - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_RESET, S_DELAY, S_GLITCH, S_OBSERVE,
    S_REPORT, S_ADVANCE, S_HIT, S_DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    tmr;
  logic [TRY_W-1:0] try_cnt;
  logic [W-1:0]     cur_delay;
  logic [W-1:0]     cur_len;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      tmr        <= '0;
      try_cnt    <= '0;
      cur_delay  <= DELAY_MIN;
      cur_len    <= LEN_MIN;
      reset_out  <= 1'b0;
      glitch_out <= 1'b0;
      rec_valid  <= 1'b0;
      rec_delay  <= '0;
      rec_len    <= '0;
      rec_result <= 2'b00;
      busy       <= 1'b0;
      hit        <= 1'b0;
      done       <= 1'b0;
    end else if (abort) begin
      state      <= S_IDLE;
      reset_out  <= 1'b0;
      glitch_out <= 1'b0;
      rec_valid  <= 1'b0;
      busy       <= 1'b0;
      hit        <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HIT, S_DONE: begin
          if (start) begin
            cur_delay <= DELAY_MIN;
            cur_len   <= LEN_MIN;
            try_cnt   <= '0;
            tmr       <= RST_LOAD;
            reset_out <= 1'b1;
            busy      <= 1'b1;
            hit       <= 1'b0;
            done      <= 1'b0;
            state     <= S_RESET;
          end
        end
        S_RESET: begin
          if (tmr == '0) begin
            reset_out <= 1'b0;
            // zero delay: glitch starts on the very first reset-low cycle
            if (cur_delay == '0) begin
              glitch_out <= 1'b1;
              tmr        <= CW'(cur_len) - CW'(1);
              state      <= S_GLITCH;
            end else begin
              tmr   <= CW'(cur_delay) - CW'(1);
              state <= S_DELAY;
            end
          end else begin
            tmr <= tmr - CW'(1);
          end
        end
        S_DELAY: begin
          if (tmr == '0) begin
            glitch_out <= 1'b1;
            tmr        <= CW'(cur_len) - CW'(1);
            state      <= S_GLITCH;
          end else begin
            tmr <= tmr - CW'(1);
          end
        end
        S_GLITCH: begin
          if (tmr == '0) begin
            glitch_out <= 1'b0;
            tmr        <= OBS_LOAD;
            state      <= S_OBSERVE;
          end else begin
            tmr <= tmr - CW'(1);
          end
        end
        S_OBSERVE: begin
          if (success || fail || tmr == '0) begin
            rec_valid  <= 1'b1;
            rec_delay  <= cur_delay;
            rec_len    <= cur_len;
            rec_result <= success ? 2'b01 : (fail ? 2'b00 : 2'b10);
            state      <= S_REPORT;
          end else begin
            tmr <= tmr - CW'(1);
          end
        end
        S_REPORT: begin
          if (rec_ready) begin
            rec_valid <= 1'b0;
            if (rec_result == 2'b01) begin
              busy  <= 1'b0;
              hit   <= 1'b1;
              state <= S_HIT;
            end else begin
              state <= S_ADVANCE;
            end
          end
        end
        S_ADVANCE: begin
          if (try_cnt != TRY_LAST) begin
            try_cnt   <= try_cnt + TRY_W'(1);
            tmr       <= RST_LOAD;
            reset_out <= 1'b1;
            state     <= S_RESET;
          end else begin
            try_cnt <= '0;
            if (cur_delay < DELAY_MAX) begin
              cur_delay <= cur_delay + W'(1);
              tmr       <= RST_LOAD;
              reset_out <= 1'b1;
              state     <= S_RESET;
            end else if (cur_len < LEN_MAX) begin
              cur_delay <= DELAY_MIN;
              cur_len   <= cur_len + W'(1);
              tmr       <= RST_LOAD;
              reset_out <= 1'b1;
              state     <= S_RESET;
            end else begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end
          end
        end
        default: begin
          reset_out  <= 1'b0;
          glitch_out <= 1'b0;
          rec_valid  <= 1'b0;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// Directed bench for glitch_sweep_ctrl: three small-grid instances exercised in sequence.
module tb_glitch_sweep_ctrl;

  logic        CLK;
  logic        RST;
  logic [2:0]  start;
  logic        abort, success, fail, rec_ready;
  logic [2:0]  ro, go, rv, bz, ht, dn;
  logic [15:0] rd [3];
  logic [15:0] rl [3];
  logic [1:0]  rr [3];

  int checks   = 0;
  int failures = 0;
  int sel      = 0;
  int n;
  int stable;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  glitch_sweep_ctrl #(.W(16), .RESET_CYCLES(4), .DELAY_MIN(16'd3), .DELAY_MAX(16'd3),
                      .LEN_MIN(16'd2), .LEN_MAX(16'd2), .OBSERVE_CYCLES(24'd8)) u_a (
    .CLK(CLK), .RST(RST), .start(start[0]), .abort(abort), .success(success), .fail(fail),
    .reset_out(ro[0]), .glitch_out(go[0]), .rec_valid(rv[0]), .rec_ready(rec_ready),
    .rec_delay(rd[0]), .rec_len(rl[0]), .rec_result(rr[0]),
    .busy(bz[0]), .hit(ht[0]), .done(dn[0]));

  glitch_sweep_ctrl #(.W(16), .RESET_CYCLES(4), .DELAY_MIN(16'd5), .DELAY_MAX(16'd6),
                      .LEN_MIN(16'd1), .LEN_MAX(16'd2), .OBSERVE_CYCLES(24'd8)) u_b (
    .CLK(CLK), .RST(RST), .start(start[1]), .abort(abort), .success(success), .fail(fail),
    .reset_out(ro[1]), .glitch_out(go[1]), .rec_valid(rv[1]), .rec_ready(rec_ready),
    .rec_delay(rd[1]), .rec_len(rl[1]), .rec_result(rr[1]),
    .busy(bz[1]), .hit(ht[1]), .done(dn[1]));

  glitch_sweep_ctrl #(.W(16), .RESET_CYCLES(4), .DELAY_MIN(16'd0), .DELAY_MAX(16'd0),
                      .LEN_MIN(16'd1), .LEN_MAX(16'd1), .OBSERVE_CYCLES(24'd8)) u_c (
    .CLK(CLK), .RST(RST), .start(start[2]), .abort(abort), .success(success), .fail(fail),
    .reset_out(ro[2]), .glitch_out(go[2]), .rec_valid(rv[2]), .rec_ready(rec_ready),
    .rec_delay(rd[2]), .rec_len(rl[2]), .rec_result(rr[2]),
    .busy(bz[2]), .hit(ht[2]), .done(dn[2]));

  function automatic logic sig(input int k);
    case (k)
      0: return ro[sel];
      1: return go[sel];
      2: return rv[sel];
      3: return bz[sel];
      4: return ht[sel];
      default: return dn[sel];
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // counts negedges until signal k reaches lvl; returns bound on timeout
  task automatic wait_level(input int k, input logic lvl, input int bound, output int cnt);
    cnt = 0;
    while (sig(k) !== lvl && cnt < bound) begin
      @(negedge CLK);
      cnt++;
    end
  endtask

  task automatic pulse_start(input int k);
    start[k] = 1'b1;
    @(negedge CLK);
    start[k] = 1'b0;
  endtask

  task automatic accept();
    rec_ready = 1'b1;
    @(negedge CLK);
    rec_ready = 1'b0;
  endtask

  task automatic check_rec(input string tag, input int d, input int l, input int r);
    check({tag, "_valid"}, 32'(rv[sel]), 32'd1);
    check({tag, "_rec"}, {rd[sel], rl[sel]} , {16'(d), 16'(l)});
    check({tag, "_res"}, 32'(rr[sel]), 32'(r));
  endtask

  task automatic run_to_observe(input string tag, input int exp_len);
    int c;
    wait_level(1, 1'b1, 200, c);
    check({tag, "_glitch_rise"}, 32'(sig(1)), 32'd1);
    wait_level(1, 1'b0, 200, c);
    check({tag, "_glitch_len"}, 32'(c), 32'(exp_len));
  endtask

  int exp_d [4] = '{5, 6, 5, 6};
  int exp_l [4] = '{1, 1, 2, 2};

  initial begin
    RST = 1'b1; start = '0; abort = 1'b0; success = 1'b0; fail = 1'b0; rec_ready = 1'b0;
    repeat (3) @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_outs%0d", i), 32'({ro[i], go[i], rv[i], bz[i], ht[i], dn[i]}), 32'd0);
      check($sformatf("rst_rec%0d", i), {rd[i], rl[i]} | 32'(rr[i]), 32'd0);
    end

    // timeout attempt on a single-point grid
    sel = 0;
    pulse_start(0);
    check("a_busy", 32'(bz[0]), 32'd1);
    wait_level(0, 1'b0, 100, n);
    check("a_reset_len", 32'(n), 32'd4);
    wait_level(1, 1'b1, 100, n);
    check("a_delay", 32'(n), 32'd3);
    wait_level(1, 1'b0, 100, n);
    check("a_glitch_len", 32'(n), 32'd2);
    wait_level(2, 1'b1, 100, n);
    check("a_observe_len", 32'(n), 32'd8);
    check_rec("a", 3, 2, 2);
    accept();
    check("a_valid_drop", 32'(rv[0]), 32'd0);
    wait_level(5, 1'b1, 20, n);
    check("a_done", 32'({dn[0], bz[0], n[7:0]}), {22'd0, 2'b10, 8'd1});

    // full 2x2 grid, every attempt classified as miss
    sel = 1;
    pulse_start(1);
    for (int a = 0; a < 4; a++) begin
      run_to_observe($sformatf("b%0d", a), exp_l[a]);
      fail = 1'b1;
      @(negedge CLK);
      fail = 1'b0;
      check_rec($sformatf("b%0d", a), exp_d[a], exp_l[a], 0);
      accept();
    end
    wait_level(5, 1'b1, 20, n);
    check("b_done", 32'({dn[1], bz[1], n[7:0]}), {22'd0, 2'b10, 8'd1});

    // restart from DONE, hit on second attempt with back-pressure
    pulse_start(1);
    run_to_observe("h0", 1);
    fail = 1'b1;
    @(negedge CLK);
    fail = 1'b0;
    check_rec("h0", 5, 1, 0);
    accept();
    run_to_observe("h1", 1);
    success = 1'b1;
    @(negedge CLK);
    success = 1'b0;
    check_rec("h1", 6, 1, 1);
    stable = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (rv[1] === 1'b1 && rd[1] === 16'd6 && rl[1] === 16'd1 && rr[1] === 2'b01 &&
          ro[1] === 1'b0 && go[1] === 1'b0)
        stable++;
    end
    check("h_stall_stable", 32'(stable), 32'd20);
    accept();
    check("h_hit", 32'({ro[1], go[1], rv[1], bz[1], ht[1]}), 32'b00001);
    repeat (10) @(negedge CLK);
    check("h_hold", 32'({ro[1], go[1], rv[1], bz[1], ht[1]}), 32'b00001);
    pulse_start(1);
    check("h_restart", 32'({ro[1], bz[1], ht[1]}), 32'b110);
    run_to_observe("r0", 1);
    fail = 1'b1;
    @(negedge CLK);
    fail = 1'b0;
    check_rec("r0", 5, 1, 0);
    accept();

    // abort while the glitch is firing
    wait_level(1, 1'b1, 200, n);
    check("ab_g_pre", 32'(go[1]), 32'd1);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    check("ab_g_post", 32'({ro[1], go[1], rv[1], bz[1]}), 32'd0);
    repeat (5) @(negedge CLK);
    check("ab_g_idle", 32'({ro[1], go[1], rv[1], bz[1]}), 32'd0);

    // abort while a record is stalled
    pulse_start(1);
    run_to_observe("ab_r", 1);
    fail = 1'b1;
    @(negedge CLK);
    fail = 1'b0;
    check("ab_r_pre", 32'(rv[1]), 32'd1);
    abort = 1'b1;
    @(negedge CLK);
    abort = 1'b0;
    check("ab_r_post", 32'({ro[1], go[1], rv[1], bz[1]}), 32'd0);

    // zero delay, simultaneous success and fail
    sel = 2;
    pulse_start(2);
    wait_level(0, 1'b0, 100, n);
    check("c_reset_len", 32'(n), 32'd4);
    check("c_glitch_same_cycle", 32'(go[2]), 32'd1);
    wait_level(1, 1'b0, 100, n);
    check("c_glitch_len", 32'(n), 32'd1);
    success = 1'b1;
    fail = 1'b1;
    @(negedge CLK);
    success = 1'b0;
    fail = 1'b0;
    check_rec("c", 0, 1, 1);
    accept();
    check("c_hit", 32'({ht[2], bz[2], ro[2]}), 32'b100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
